// File: rtl/execute_mc_pkg.sv
// Shared widths, instruction-class indices, status bit indices and FSM encoding
// for the multi-cycle execute stage.
package execute_mc_pkg;

    localparam int unsigned W_DOPC = 11;
    localparam int unsigned W_OPC  = 2;
    localparam int unsigned W_CC   = 3;
    localparam int unsigned W_MEMC = 4;

    // One-hot instruction class bit positions in dopc; all-zero is a nop
    localparam int unsigned D_ADDSUB = 0;
    localparam int unsigned D_MUL    = 1;
    localparam int unsigned D_ABS    = 2;
    localparam int unsigned D_SHIFT  = 3;
    localparam int unsigned D_LOGIC  = 4;
    localparam int unsigned D_SET    = 5;
    localparam int unsigned D_DIV    = 6;
    localparam int unsigned D_LOAD   = 7;
    localparam int unsigned D_STORE  = 8;
    localparam int unsigned D_JUMP   = 9;
    localparam int unsigned D_HALT   = 10;

    // Status register bit positions
    localparam int unsigned S_Z = 0;
    localparam int unsigned S_N = 1;
    localparam int unsigned S_C = 2;
    localparam int unsigned S_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_MEM  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Jump condition: 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 V, 7 never
    function automatic logic cond_met(input logic [W_CC-1:0] cc,
                                      input logic z, input logic n,
                                      input logic c, input logic v);
        logic r;
        case (cc)
            3'd0:    r = 1'b1;
            3'd1:    r = z;
            3'd2:    r = ~z;
            3'd3:    r = n;
            3'd4:    r = ~n;
            3'd5:    r = c;
            3'd6:    r = v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_mc_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is
// taken on the start edge so results are stable during the final busy cycle,
// where done is high. Divide by zero finishes after a single cycle.
module div_iter #(
    parameter int unsigned WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WORD-1:0] dividend,
    input  logic [WORD-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] quot,
    output logic [WORD-1:0] rem
);

    localparam int unsigned W_CNT = $clog2(WORD + 1);

    logic [WORD-1:0]  dvs_r;
    logic [W_CNT-1:0] cnt_r;
    logic [WORD-1:0]  q_in;
    logic [WORD-1:0]  r_in;
    logic [WORD-1:0]  d_in;
    logic [WORD:0]    shifted;
    logic [WORD:0]    trial;
    logic [WORD-1:0]  step_q;
    logic [WORD-1:0]  step_r;

    // One restoring step on either the fresh operands or the running state
    always_comb begin
        q_in    = start ? dividend : quot;
        r_in    = start ? '0 : rem;
        d_in    = start ? divisor : dvs_r;
        shifted = {r_in, q_in[WORD-1]};
        trial   = shifted - {1'b0, d_in};
        if (trial[WORD]) begin
            step_r = shifted[WORD-1:0];
            step_q = {q_in[WORD-2:0], 1'b0};
        end else begin
            step_r = trial[WORD-1:0];
            step_q = {q_in[WORD-2:0], 1'b1};
        end
    end

    assign done = busy && (cnt_r == W_CNT'(WORD));

    // Iteration state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            cnt_r <= '0;
            dvs_r <= '0;
            quot  <= '0;
            rem   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            dvs_r <= divisor;
            if (divisor == '0) begin
                quot  <= '1;
                rem   <= dividend;
                cnt_r <= W_CNT'(WORD);
            end else begin
                quot  <= step_q;
                rem   <= step_r;
                cnt_r <= W_CNT'(1);
            end
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                quot  <= step_q;
                rem   <= step_r;
                cnt_r <= cnt_r + W_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: single-cycle ALU classes, iterative divide,
// latency-configurable data-memory access, jumps and a sticky halt.
module execute_mc
    import execute_mc_pkg::*;
#(
    parameter int unsigned WORD     = 32,
    parameter int unsigned ADDR     = 16,
    parameter int unsigned W_RD     = 5,
    parameter int unsigned W_STATUS = 4,
    parameter int unsigned DM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    output logic              stall_o,
    input  logic [WORD-1:0]   src_i,
    input  logic [WORD-1:0]   dest_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_rd_name_i,
    input  logic [W_DOPC-1:0] dopc_i,
    input  logic [W_OPC-1:0]  opc_i,
    input  logic [ADDR-1:0]   origaddr_i,
    input  logic [W_CC-1:0]   cc_i,
    output logic              branch_o,
    output logic [ADDR-1:0]   baddr_o,
    output logic              wb_o,
    output logic [W_RD-1:0]   wb_rd_name_o,
    output logic [WORD-1:0]   wb_rd_data_o,
    output logic              dm_w_o,
    output logic [WORD-1:0]   dm_data_o,
    input  logic [WORD-1:0]   dm_data_i,
    output logic              halted_o
);

    localparam int unsigned W_SH = $clog2(WORD);
    localparam logic [W_MEMC-1:0] MEM_LAST = W_MEMC'(DM_LAT);

    state_e              state_r, state_n;
    logic [W_STATUS-1:0] status_r, status_n;
    logic [W_MEMC-1:0]   mem_cnt_r, mem_cnt_n;
    logic                wb_n;
    logic [W_RD-1:0]     name_n;
    logic [WORD-1:0]     data_n;
    logic                stall_c, branch_c, dm_w_c, div_start_c, accept_c;
    logic                alu_op_c, mem_op_c, taken_c;

    logic [W_RD-1:0]     lat_rd;
    logic                lat_wb, lat_rem, lat_store, lat_div0;
    logic [WORD-1:0]     lat_dest;

    logic [WORD:0]       sum_c;
    logic [WORD-1:0]     alu_res;
    logic                alu_c, alu_v, lt_c;

    logic                div_busy, div_done;
    logic [WORD-1:0]     div_quot, div_rem, div_res;

    div_iter #(.WORD(WORD)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (src_i),
        .divisor  (dest_i),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    assign accept_c = (state_r == ST_IDLE) && v_i;
    assign alu_op_c = |dopc_i[D_SET:D_ADDSUB];
    assign mem_op_c = dopc_i[D_LOAD] | dopc_i[D_STORE];
    assign taken_c  = cond_met(cc_i, status_r[S_Z], status_r[S_N], status_r[S_C], status_r[S_V]);
    assign div_res  = lat_rem ? div_rem : div_quot;

    // Single-cycle ALU result and carry/overflow for the presented instruction
    always_comb begin
        sum_c   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        lt_c    = opc_i[0] ? ($signed(src_i) < $signed(dest_i)) : (src_i < dest_i);
        if (dopc_i[D_ADDSUB]) begin
            if (opc_i[0]) begin
                sum_c = {1'b0, src_i} - {1'b0, dest_i};
                alu_v = (src_i[WORD-1] != dest_i[WORD-1]) && (sum_c[WORD-1] != src_i[WORD-1]);
            end else begin
                sum_c = {1'b0, src_i} + {1'b0, dest_i};
                alu_v = (src_i[WORD-1] == dest_i[WORD-1]) && (sum_c[WORD-1] != src_i[WORD-1]);
            end
            alu_res = sum_c[WORD-1:0];
            alu_c   = sum_c[WORD];
        end else if (dopc_i[D_MUL]) begin
            alu_res = src_i * dest_i;
        end else if (dopc_i[D_ABS]) begin
            alu_res = src_i[WORD-1] ? (~src_i + WORD'(1)) : src_i;
            alu_v   = (src_i == {1'b1, {(WORD-1){1'b0}}});
        end else if (dopc_i[D_SHIFT]) begin
            case (opc_i)
                2'd0:    alu_res = src_i << dest_i[W_SH-1:0];
                2'd1:    alu_res = src_i >> dest_i[W_SH-1:0];
                default: alu_res = WORD'($signed(src_i) >>> dest_i[W_SH-1:0]);
            endcase
        end else if (dopc_i[D_LOGIC]) begin
            case (opc_i)
                2'd0:    alu_res = src_i & dest_i;
                2'd1:    alu_res = src_i | dest_i;
                2'd2:    alu_res = src_i ^ dest_i;
                default: alu_res = ~src_i;
            endcase
        end else if (dopc_i[D_SET]) begin
            alu_res = {{(WORD-1){1'b0}}, lt_c};
        end
    end

    // Next state, stall/branch/strobe and writeback/status next values
    always_comb begin
        state_n     = state_r;
        stall_c     = 1'b0;
        branch_c    = 1'b0;
        dm_w_c      = 1'b0;
        div_start_c = 1'b0;
        mem_cnt_n   = mem_cnt_r;
        wb_n        = 1'b0;
        name_n      = wb_rd_name_o;
        data_n      = wb_rd_data_o;
        status_n    = status_r;
        case (state_r)
            ST_IDLE: begin
                if (v_i) begin
                    status_n = '0;
                    if (dopc_i[D_DIV]) begin
                        stall_c     = 1'b1;
                        div_start_c = 1'b1;
                        state_n     = ST_DIV;
                    end else if (mem_op_c && (DM_LAT != 0)) begin
                        stall_c   = 1'b1;
                        mem_cnt_n = W_MEMC'(1);
                        state_n   = ST_MEM;
                    end else if (dopc_i[D_HALT]) begin
                        state_n = ST_HALT;
                    end else begin
                        wb_n     = wb_i & (alu_op_c | dopc_i[D_LOAD]);
                        name_n   = wb_rd_name_i;
                        data_n   = dopc_i[D_LOAD] ? dm_data_i : alu_res;
                        dm_w_c   = dopc_i[D_STORE];
                        branch_c = dopc_i[D_JUMP] & taken_c;
                        if (alu_op_c) begin
                            status_n[S_Z] = (alu_res == '0);
                            status_n[S_N] = alu_res[WORD-1];
                            status_n[S_C] = alu_c;
                            status_n[S_V] = alu_v;
                        end else if (dopc_i[D_LOAD]) begin
                            status_n[S_Z] = (dm_data_i == '0);
                            status_n[S_N] = dm_data_i[WORD-1];
                        end
                    end
                end
            end
            ST_DIV: begin
                stall_c = div_busy & ~div_done;
                if (div_done) begin
                    state_n       = ST_IDLE;
                    wb_n          = lat_wb;
                    name_n        = lat_rd;
                    data_n        = div_res;
                    status_n      = '0;
                    status_n[S_Z] = (div_res == '0);
                    status_n[S_V] = lat_div0;
                end
            end
            ST_MEM: begin
                stall_c = 1'b1;
                if (mem_cnt_r == MEM_LAST) begin
                    stall_c  = 1'b0;
                    state_n  = ST_IDLE;
                    status_n = '0;
                    if (lat_store) begin
                        dm_w_c = v_i;
                    end else begin
                        wb_n          = lat_wb;
                        name_n        = lat_rd;
                        data_n        = dm_data_i;
                        status_n[S_Z] = (dm_data_i == '0);
                        status_n[S_N] = dm_data_i[WORD-1];
                    end
                end else begin
                    mem_cnt_n = mem_cnt_r + W_MEMC'(1);
                end
            end
            ST_HALT: begin
                stall_c = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM, status and writeback registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            status_r     <= '0;
            mem_cnt_r    <= '0;
            wb_o         <= 1'b0;
            wb_rd_name_o <= '0;
            wb_rd_data_o <= '0;
        end else begin
            state_r      <= state_n;
            status_r     <= status_n;
            mem_cnt_r    <= mem_cnt_n;
            wb_o         <= wb_n;
            wb_rd_name_o <= name_n;
            wb_rd_data_o <= data_n;
        end
    end

    // Context of the accepted instruction, used by the multi-cycle classes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_rd    <= '0;
            lat_wb    <= 1'b0;
            lat_rem   <= 1'b0;
            lat_store <= 1'b0;
            lat_div0  <= 1'b0;
            lat_dest  <= '0;
        end else if (accept_c) begin
            lat_rd    <= wb_rd_name_i;
            lat_wb    <= wb_i;
            lat_rem   <= opc_i[0];
            lat_store <= dopc_i[D_STORE];
            lat_div0  <= (dest_i == '0);
            lat_dest  <= dest_i;
        end
    end

    assign stall_o   = rst & stall_c;
    assign branch_o  = rst & branch_c;
    assign dm_w_o    = rst & dm_w_c;
    assign baddr_o   = origaddr_i + src_i[ADDR-1:0];
    assign dm_data_o = (state_r == ST_MEM) ? lat_dest : dest_i;
    assign halted_o  = (state_r == ST_HALT);

endmodule
